// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
//
// Per-player movement stage feeding the action block. On every falling edge of
// the frame clock it turns the held direction buttons into a registered sprite
// location and facing. Moves are checked against the counter layout and the
// other player's sprite. The outputs are registered, so they stay stable for a
// whole frame while the action block derives the grid cell and the object in
// front of the player.
//
// Parameters
//   SPEED      normal step in pixels per frame (must divide 32)
//   RAMP       consecutive committed frames in one direction before the fast
//              step (2*SPEED) is tried
//   START_X/Y  reset location (top-left of the 32x32 sprite)
//   START_DIR  reset facing (0 LEFT, 1 RIGHT, 2 UP, 3 DOWN)
//
// Ports
//   vsync              frame clock, state updates on its negedge
//   reset              synchronous, active-high
//   left/right/up/down held-level direction buttons
//   game_state         0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
//   player_state       from action; 1 = P_CHOPPING
//   solid              [row][col] map, 1 = counter cell (not walkable)
//   other_en           another player is present
//   other_x/other_y    the other player's location
//   player_loc_x/y     sprite top-left in pixels
//   player_direction   facing, 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
//   moving             location changed on the last update
// -----------------------------------------------------------------------------
module player_motion #(
   parameter int SPEED     = 2,
   parameter int RAMP      = 15,
   parameter int START_X   = 64,
   parameter int START_Y   = 96,
   parameter int START_DIR = 3
) (
   input  logic             vsync,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic             up,
   input  logic             down,
   input  logic [2:0]       game_state,
   input  logic [3:0]       player_state,
   input  logic [7:0][12:0] solid,
   input  logic             other_en,
   input  logic [8:0]       other_x,
   input  logic [8:0]       other_y,
   output logic [8:0]       player_loc_x,
   output logic [8:0]       player_loc_y,
   output logic [1:0]       player_direction,
   output logic             moving
);

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   // A candidate location. Coordinates carry one extra bit so that a right or
   // down step past 511 is still seen (and rejected as off-grid) instead of
   // wrapping back onto the floor.
   typedef struct packed {
      logic       borrow;
      logic [9:0] x;
      logic [9:0] y;
   } cand_t;

   localparam logic [2:0]        GS_PLAY     = 3'd2;
   localparam logic [3:0]        P_CHOPPING  = 4'd1;
   localparam int                HOLD_W      = (RAMP < 1) ? 1 : $clog2(RAMP + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(RAMP);
   localparam logic [9:0]        STEP_NORM   = 10'(SPEED);
   localparam logic [9:0]        STEP_FAST   = 10'(2 * SPEED);
   localparam logic [9:0]        SPRITE_SPAN = 10'd31;
   localparam logic [9:0]        SPRITE_SIZE = 10'd32;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Location after one step of 'step' pixels in 'dir'. A step below zero is
   // flagged as a borrow rather than trusted after wrap-around.
   function automatic cand_t make_cand(input dir_t       dir,
                                       input logic [8:0] x,
                                       input logic [8:0] y,
                                       input logic [9:0] step);
      cand_t c;
      c.borrow = 1'b0;
      c.x      = {1'b0, x};
      c.y      = {1'b0, y};
      case (dir)
         DIR_LEFT: begin
            c.borrow = (c.x < step);
            c.x      = c.x - step;
         end
         DIR_RIGHT: c.x = c.x + step;
         DIR_UP: begin
            c.borrow = (c.y < step);
            c.y      = c.y - step;
         end
         default:   c.y = c.y + step;
      endcase
      return c;
   endfunction

   // A pixel lies in a blocked cell when the cell is a counter or when it falls
   // outside the 13x8 grid.
   function automatic logic cell_blocked(input logic [9:0]       px,
                                         input logic [9:0]       py,
                                         input logic [7:0][12:0] map);
      logic [9:0] col;
      logic [9:0] row;
      col = px >> 5;
      row = py >> 5;
      if (col > 10'd12 || row > 10'd7) begin
         return 1'b1;
      end
      return map[row[2:0]][col[3:0]];
   endfunction

   // Two 32x32 boxes overlap when both axis distances are below the box size.
   function automatic logic boxes_overlap(input logic [9:0] cx,
                                          input logic [9:0] cy,
                                          input logic [8:0] ox,
                                          input logic [8:0] oy);
      logic [9:0] dx;
      logic [9:0] dy;
      dx = (cx >= {1'b0, ox}) ? (cx - {1'b0, ox}) : ({1'b0, ox} - cx);
      dy = (cy >= {1'b0, oy}) ? (cy - {1'b0, oy}) : ({1'b0, oy} - cy);
      return (dx < SPRITE_SIZE) && (dy < SPRITE_SIZE);
   endfunction

   // A candidate is legal when it did not borrow, all four sprite corners sit
   // on walkable cells, and it does not overlap the other player.
   function automatic logic cand_legal(input cand_t            c,
                                       input logic [7:0][12:0] map,
                                       input logic             oth_en,
                                       input logic [8:0]       ox,
                                       input logic [8:0]       oy);
      logic [9:0] x_far;
      logic [9:0] y_far;
      logic       walls_clear;
      x_far = c.x + SPRITE_SPAN;
      y_far = c.y + SPRITE_SPAN;
      walls_clear = !cell_blocked(c.x,   c.y,   map) &&
                    !cell_blocked(x_far, c.y,   map) &&
                    !cell_blocked(c.x,   y_far, map) &&
                    !cell_blocked(x_far, y_far, map);
      return !c.borrow && walls_clear &&
             !(oth_en && boxes_overlap(c.x, c.y, ox, oy));
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [8:0]        r_loc_x;
   logic [8:0]        r_loc_y;
   dir_t              r_dir;
   logic              r_moving;
   logic [HOLD_W-1:0] r_hold_cnt;

   logic [8:0]        w_loc_x_next;
   logic [8:0]        w_loc_y_next;
   dir_t              w_dir_next;
   logic              w_moving_next;
   logic [HOLD_W-1:0] w_hold_next;

   logic              w_frozen;
   logic              w_any_btn;
   dir_t              w_req_dir;
   cand_t             w_cand_fast;
   cand_t             w_cand_norm;
   logic              w_fast_ok;
   logic              w_norm_ok;
   logic              w_commit;
   cand_t             w_cand_take;
   logic [HOLD_W-1:0] w_hold_inc;

   // ---------------------------------------------------------------------------
   // Request decode and candidate evaluation
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can
      // leave one unassigned and infer a latch.
      w_req_dir = DIR_DOWN;
      if (left) begin
         w_req_dir = DIR_LEFT;
      end else if (right) begin
         w_req_dir = DIR_RIGHT;
      end else if (up) begin
         w_req_dir = DIR_UP;
      end
   end

   assign w_frozen  = (game_state != GS_PLAY) || (player_state == P_CHOPPING);
   assign w_any_btn = left | right | up | down;

   assign w_cand_fast = make_cand(w_req_dir, r_loc_x, r_loc_y, STEP_FAST);
   assign w_cand_norm = make_cand(w_req_dir, r_loc_x, r_loc_y, STEP_NORM);

   // The fast step is only considered once the ramp is complete; when it is
   // blocked the normal step is still tried so the sprite can sit flush
   // against an obstacle.
   assign w_fast_ok   = (r_hold_cnt >= HOLD_MAX) &&
                        cand_legal(w_cand_fast, solid, other_en, other_x, other_y);
   assign w_norm_ok   = cand_legal(w_cand_norm, solid, other_en, other_x, other_y);
   assign w_commit    = w_fast_ok || w_norm_ok;
   assign w_cand_take = w_fast_ok ? w_cand_fast : w_cand_norm;

   // A nonzero count means the previous frame committed a move, and that move
   // went the way the sprite is currently facing.
   assign w_hold_inc = (r_hold_cnt != '0 && w_req_dir == r_dir)
                       ? ((r_hold_cnt >= HOLD_MAX) ? HOLD_MAX : r_hold_cnt + HOLD_W'(1))
                       : HOLD_W'(1);

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_loc_x_next  = r_loc_x;
      w_loc_y_next  = r_loc_y;
      w_dir_next    = r_dir;
      w_moving_next = 1'b0;
      w_hold_next   = '0;

      if (!w_frozen && w_any_btn) begin
         // Facing follows the request even when the step is blocked, so the
         // player can turn to face a counter.
         w_dir_next = w_req_dir;
         if (w_commit) begin
            // A legal candidate never exceeds the grid, so bit 9 is always 0.
            w_loc_x_next  = w_cand_take.x[8:0];
            w_loc_y_next  = w_cand_take.y[8:0];
            w_moving_next = 1'b1;
            w_hold_next   = w_hold_inc;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(negedge vsync) begin
      if (reset) begin
         r_loc_x    <= 9'(START_X);
         r_loc_y    <= 9'(START_Y);
         r_dir      <= dir_t'(2'(START_DIR));
         r_moving   <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_loc_x    <= w_loc_x_next;
         r_loc_y    <= w_loc_y_next;
         r_dir      <= w_dir_next;
         r_moving   <= w_moving_next;
         r_hold_cnt <= w_hold_next;
      end
   end

   assign player_loc_x     = r_loc_x;
   assign player_loc_y     = r_loc_y;
   assign player_direction = r_dir;
   assign moving           = r_moving;

endmodule

// File: doc/player_motion.md
# player_motion

Per-player movement stage sitting directly upstream of `action`. Once per frame it turns the debounced direction buttons into a registered sprite location (`player_loc_x`, `player_loc_y`) and facing (`player_direction`). Movement is checked against the counter layout and the other player's sprite. `action` derives the grid cell and the object in front from these outputs, so they must stay stable for a whole frame.

## Interface
Parameters:
- `SPEED`, 2: normal step in pixels per frame. It must divide 32.
- `RAMP`, 15: consecutive accepted frames in one direction before the fast step (2*SPEED) is used.
- `START_X`, 64: reset x location (top-left of the 32x32 sprite).
- `START_Y`, 96: reset y location.
- `START_DIR`, 3: reset facing (DOWN).

Ports:
- `vsync`  in  1  frame clock; all state updates on its negedge.
- `reset`  in  1  synchronous, active-high.
- `left`, `right`, `up`, `down`  in  1 each  held-level direction buttons.
- `game_state`  in  3  0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH.
- `player_state`  in  4  from `action`; 1 = P_CHOPPING.
- `solid`  in  [7:0][12:0]  1 = counter cell (not walkable), indexed [row][col].
- `other_en`  in  1  another player is present.
- `other_x`, `other_y`  in  9 each  the other player's location.
- `player_loc_x`, `player_loc_y`  out  9 each  sprite top-left in pixels.
- `player_direction`  out  2  0 LEFT, 1 RIGHT, 2 UP, 3 DOWN.
- `moving`  out  1  location changed on the last update.

## Operation
- **Reset.**
  - Location is (START_X, START_Y) and `player_direction` is START_DIR.
  - `moving` = 0 and `hold_cnt` = 0.
- **Frozen.** The block is frozen when `game_state` != PLAY or `player_state` == P_CHOPPING.
  - Location and direction hold.
  - `moving` = 0 and `hold_cnt` = 0.
- **Request.** When not frozen, the first pressed button in priority order LEFT > RIGHT > UP > DOWN is the request.
  - With no button pressed: location and direction hold, `moving` = 0, `hold_cnt` = 0.
  - `player_direction` takes the requested direction every frame, even if the move is blocked. This lets the player face a counter.
- **Candidate check.** A candidate location (cx, cy) is legal only if both conditions hold.
  - Walls: each of its four corners (cx,cy), (cx+31,cy), (cx,cy+31), (cx+31,cy+31) maps to a cell (col = px>>5, row = py>>5) with `solid` = 0. Arithmetic is 10-bit.
  - A corner with col > 12 or row > 7 counts as solid.
  - A step below 0 (borrow) is illegal.
  - Other player: if `other_en`, the boxes must not overlap. They overlap when |cx-other_x| < 32 and |cy-other_y| < 32.
- **Step selection.**
  - If `hold_cnt` >= RAMP, try 2*SPEED first, then SPEED.
  - Otherwise try SPEED only.
  - The first legal candidate is committed.
  - If none is legal, the location holds.
- **hold_cnt.**
  - Increments (saturating at RAMP) on each committed move in the same direction as the previous committed move.
  - Becomes 1 on a committed move in a new direction.
  - Becomes 0 on a blocked frame.
- **Moving.** `moving` = 1 only on frames where a step was committed.

## Timing
- One update per negedge `vsync`. Inputs are sampled at that edge; all outputs are registered.
- Latency is zero frames: a button held at edge N changes the location at edge N.
- The fast step begins on the (RAMP+1)th consecutive committed move.
- Reset has priority over everything, including mid-ramp. Location returns to start in one edge.
- Unfreezing resumes at normal speed: `hold_cnt` is 0.
- Simultaneous buttons resolve strictly by priority. Direction never toggles within a frame.

## Test plan
- **Reset and idle.** Reset, then PLAY with no buttons for 10 frames: location (64,96), dir 3, `moving` 0 throughout.
- **Walk and ramp.** `right` held in PLAY on an open floor (border cells solid):
  - x = 66, 68, … on frames 1–15;
  - from frame 16, steps of 4;
  - stops flush at x = 352 (352+31 = 383, cell 11);
  - `moving` goes to 0 there.
- **Face blocked counter.** At y = 32, press `up`: y stays 32, dir becomes 2, `moving` 0, `hold_cnt` 0.
- **Fast-step fallback.** Ramped at x = 350 moving right: a 4 px step is illegal, so 2 px is taken and x = 352.
- **Player collision.** `other_en`=1, other at (100,96), self at (64,96) holding `right`: stops at x = 68 (68+32 = 100). With `other_en`=0 it continues.
- **Freeze and priority.**
  - `player_state` = 1 while `down` is held: location holds.
  - `game_state` = 3: location holds.
  - Back to normal, `left`+`down` pressed: dir 0, x decreases by 2.
